// File: rtl/byte_parity_pkg.sv
// Shared definitions for the byte-parity datapath: frame constants, the
// serializer state encoding and the masked-parity function used by both the
// generator and the serializer recheck.
package byte_parity_pkg;

  localparam int DATA_BITS = 8;
  localparam int WORD_W    = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  // Even-style parity over the enabled data bits only.
  function automatic logic masked_parity(input logic [DATA_BITS-1:0] data,
                                         input logic [DATA_BITS-1:0] en);
    return ^(data & en);
  endfunction

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter for the serializer. Counts 0..CLKS_PER_BIT-1 while
// enabled and wraps; tc_o marks the last cycle of a bit period. clear_i
// forces the count back to zero and wins over enable.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == LAST);

  // Next count: clear, wrap at terminal count, or increment.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tc_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/parity_byte_serializer.sv
// Transmit end of the parity datapath: one-entry holding buffer behind a
// valid/ready handshake, then start / 8 data bits LSB-first / parity /
// STOP_BITS stop bits on TXD, idle high.
// Optional parity recheck on acceptance is enabled by defining PAR_CHECK_EN.
module parity_byte_serializer
  import byte_parity_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [WORD_W-1:0] IN_DP,
  input  logic [7:0]        IN_EN,
  input  logic              IN_VALID,
  output logic              IN_READY,
  output logic              TXD,
  output logic              TX_BUSY,
  output logic              PERR,
  output logic              PERR_STICKY
);

  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [2:0] IDX_LAST  = 3'(DATA_BITS - 1);

  tx_state_e         state_q, state_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              stop_cnt_q, stop_cnt_d;
  logic              txd_q, txd_d;

  logic handshake;
  logic last_stop;
  logic take;
  logic tc;

  assign handshake = IN_VALID && !hold_full_q;
  assign last_stop = (state_q == STOP) && tc && (stop_cnt_q == STOP_LAST);
  // The shifter pulls the buffered word when idle or as the frame ends.
  assign take      = hold_full_q && ((state_q == IDLE) || last_stop);

  assign IN_READY = !hold_full_q;
  assign TXD      = txd_q;
  assign TX_BUSY  = (state_q != IDLE);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk     (CLK),
    .rst_n   (RST_N),
    .clear_i (take),
    .en_i    (state_q != IDLE),
    .tc_o    (tc)
  );

  // Holding buffer: fill on handshake, drain when the shifter takes it.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (handshake) begin
      hold_d      = IN_DP;
      hold_full_d = 1'b1;
    end else if (take) begin
      hold_full_d = 1'b0;
    end
  end

  // Frame sequencing; TXD is computed from the next state so it is registered
  // in step with the state it belongs to.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    stop_cnt_d = stop_cnt_q;
    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          state_d = START;
          shift_d = hold_q;
        end
      end
      START: begin
        if (tc) begin
          state_d   = DATA;
          bit_idx_d = '0;
        end
      end
      DATA: begin
        if (tc) begin
          // After eight shifts the parity bit sits in shift position 0.
          shift_d = shift_q >> 1;
          if (bit_idx_q == IDX_LAST) state_d = PARITY;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (tc) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (last_stop) begin
          if (hold_full_q) begin
            state_d = START;
            shift_d = hold_q;
          end else begin
            state_d = IDLE;
          end
        end else if (tc) begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:        txd_d = 1'b0;
      DATA, PARITY: txd_d = shift_d[0];
      default:      txd_d = 1'b1;
    endcase
  end

  // State, buffer and shifter registers; reset abandons any frame in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      stop_cnt_q  <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_cnt_q  <= stop_cnt_d;
      txd_q       <= txd_d;
    end
  end

`ifdef PAR_CHECK_EN
  logic perr_q, perr_sticky_q;
  logic mismatch;

  assign mismatch = (masked_parity(IN_DP[DATA_BITS-1:0], IN_EN) != IN_DP[DATA_BITS]);

  // Recheck the accepted word; the word itself is forwarded untouched.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      perr_q        <= 1'b0;
      perr_sticky_q <= 1'b0;
    end else begin
      perr_q <= handshake && mismatch;
      if (handshake && mismatch) perr_sticky_q <= 1'b1;
    end
  end

  assign PERR        = perr_q;
  assign PERR_STICKY = perr_sticky_q;
`else
  logic unused_en;
  assign unused_en   = ^IN_EN;
  assign PERR        = 1'b0;
  assign PERR_STICKY = 1'b0;
`endif

endmodule

// File: tb/tb_parity_byte_serializer.sv
// Self-checking bench for parity_byte_serializer (CLKS_PER_BIT=4). A frame
// monitor decodes TXD into words and compares them with a scoreboard queue
// filled at each handshake. A second instance covers STOP_BITS=2.
module tb_parity_byte_serializer;

  localparam int CPB        = 4;
  localparam int FRAME_BITS = 11;
  localparam int FRAME_CYC  = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] in_dp;
  logic [7:0] in_en;
  logic       in_valid;
  logic       in_ready, txd, tx_busy, perr, perr_sticky;

  logic [8:0] in_dp2;
  logic [7:0] in_en2;
  logic       in_valid2;
  logic       in_ready2, txd2, tx_busy2, perr2, perr_sticky2;

  int total = 0;
  int bad   = 0;

  logic [8:0]            sb[$];
  int                    gap_q[$];
  int                    frames_seen = 0;
  int                    idle_run    = 0;
  logic [FRAME_BITS-1:0] last_line   = '0;

  logic [FRAME_BITS-1:0] mon_line;
  bit                    mon_stable, mon_aborted;

`ifdef PAR_CHECK_EN
  localparam logic EXP_PERR = 1'b1;
`else
  localparam logic EXP_PERR = 1'b0;
`endif

  typedef struct {
    logic [8:0]            dp;
    logic [FRAME_BITS-1:0] line;  // bit 0 is sent first
  } vec_t;

  vec_t vecs[5];

  parity_byte_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .CLK(clk), .RST_N(rst_n), .IN_DP(in_dp), .IN_EN(in_en),
    .IN_VALID(in_valid), .IN_READY(in_ready), .TXD(txd), .TX_BUSY(tx_busy),
    .PERR(perr), .PERR_STICKY(perr_sticky)
  );

  parity_byte_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .CLK(clk), .RST_N(rst_n), .IN_DP(in_dp2), .IN_EN(in_en2),
    .IN_VALID(in_valid2), .IN_READY(in_ready2), .TXD(txd2), .TX_BUSY(tx_busy2),
    .PERR(perr2), .PERR_STICKY(perr_sticky2)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present one word, wait for the handshake edge, then drop valid.
  task automatic send(input logic [8:0] dp, input logic [7:0] en, input bit push);
    int n = 0;
    @(negedge clk);
    in_dp = dp; in_en = en; in_valid = 1'b1;
    while (!in_ready && n < 2000) begin @(negedge clk); n++; end
    check("send_ready_timeout", 32'(n < 2000), 1);
    @(posedge clk);
    if (push) sb.push_back(dp);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames_seen < target && n < 5000) begin @(negedge clk); n++; end
    check("frame_wait_timeout", 32'(frames_seen >= target), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((tx_busy || !in_ready) && n < 5000) begin @(negedge clk); n++; end
    check("idle_wait_timeout", 32'(n < 5000), 1);
    @(negedge clk);
  endtask

  // Frame monitor: one sample per cycle on the falling edge.
  initial begin : monitor
    logic [8:0] exp_w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idle_run = 0;
      end else if (txd !== 1'b0) begin
        idle_run++;
      end else begin
        gap_q.push_back(idle_run);
        idle_run    = 0;
        mon_line    = '0;
        mon_stable  = 1'b1;
        mon_aborted = 1'b0;
        for (int s = 0; s < FRAME_CYC; s++) begin
          if (s > 0) @(negedge clk);
          if (!rst_n) begin mon_aborted = 1'b1; break; end
          if (s % CPB == 0) mon_line[s / CPB] = txd;
          else if (txd !== mon_line[s / CPB]) mon_stable = 1'b0;
        end
        if (!mon_aborted) begin
          frames_seen++;
          last_line = mon_line;
          check("bit_period_stable", 32'(mon_stable), 1);
          check("stop_bit_high", 32'(mon_line[FRAME_BITS-1]), 1);
          check("frame_expected", 32'(sb.size() > 0), 1);
          if (sb.size() > 0) begin
            exp_w = sb.pop_front();
            check("frame_word", 32'(mon_line[9:1]), 32'(exp_w));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int busy_cnt, n, base, busy2;
    logic [11:0] line2;
    logic [8:0] words[3];

    vecs[0] = '{dp: 9'h1A5, line: 11'b1_1_10100101_0};
    vecs[1] = '{dp: 9'h000, line: 11'b1_0_00000000_0};
    vecs[2] = '{dp: 9'h0FF, line: 11'b1_0_11111111_0};
    vecs[3] = '{dp: 9'h13C, line: 11'b1_1_00111100_0};
    vecs[4] = '{dp: 9'h0C3, line: 11'b1_0_11000011_0};

    rst_n = 1'b0; in_dp = '0; in_en = 8'hFF; in_valid = 1'b0;
    in_dp2 = '0; in_en2 = 8'hFF; in_valid2 = 1'b0;
    #23;
    check("rst_txd", 32'(txd), 1);
    check("rst_busy", 32'(tx_busy), 0);
    check("rst_ready", 32'(in_ready), 1);
    check("rst_perr", 32'(perr), 0);
    check("rst_sticky", 32'(perr_sticky), 0);
    check("rst_txd2", 32'(txd2), 1);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table: single frames with latency, busy length and line contents.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].dp, 8'hFF, 1'b1);
      check("lat_txd_after_accept", 32'(txd), 1);
      check("lat_busy_after_accept", 32'(tx_busy), 0);
      check("lat_ready_full", 32'(in_ready), 0);
      @(posedge clk); #1;
      check("lat_txd_start", 32'(txd), 0);
      check("lat_busy_start", 32'(tx_busy), 1);
      check("lat_ready_drained", 32'(in_ready), 1);
      busy_cnt = 0; n = 0;
      while (tx_busy && n < 500) begin
        @(negedge clk);
        if (tx_busy) busy_cnt++;
        n++;
      end
      check("busy_frame_len", 32'(busy_cnt), 32'(FRAME_CYC));
      check("line_pattern", 32'(last_line), 32'(vecs[i].line));
    end

    // Back-to-back with valid held; garbage on IN_DP while not ready.
    wait_idle();
    words[0] = 9'h155; words[1] = 9'h0AA; words[2] = 9'h1E1;
    gap_q.delete();
    base = frames_seen;
    begin
      int idx = 0;
      int cyc = 0;
      bit acc;
      @(negedge clk);
      in_valid = 1'b1;
      while (idx < 3 && cyc < 1000) begin
        acc = in_ready;
        in_dp = acc ? words[idx] : 9'($urandom);
        @(posedge clk);
        if (acc) begin
          sb.push_back(words[idx]);
          idx++;
          #1 check("b2b_ready_low_when_full", 32'(in_ready), 0);
        end
        @(negedge clk);
        cyc++;
      end
      in_valid = 1'b0;
      check("b2b_accept_count", 32'(idx), 3);
    end
    wait_frames(base + 3);
    check("b2b_gap_count", 32'(gap_q.size()), 3);
    if (gap_q.size() == 3) begin
      check("b2b_gap_1", 32'(gap_q[1]), 0);
      check("b2b_gap_2", 32'(gap_q[2]), 0);
    end

    // Parity recheck: good word, then bad word forwarded unchanged.
    wait_idle();
    send(9'h0FF, 8'hFF, 1'b1);
    check("perr_good_word", 32'(perr), 0);
    wait_idle();
    send(9'h1FF, 8'hFF, 1'b1);
    check("perr_bad_word", 32'(perr), 32'(EXP_PERR));
    @(posedge clk); #1;
    check("perr_one_cycle", 32'(perr), 0);
    check("perr_sticky_set", 32'(perr_sticky), 32'(EXP_PERR));
    wait_idle();
    check("bad_word_line", 32'(last_line), 32'(11'b1_1_11111111_0));
    check("perr_sticky_holds", 32'(perr_sticky), 32'(EXP_PERR));

    // Reset during DATA bit 3.
    send(9'h0F0, 8'hFF, 1'b0);
    n = 0;
    while (txd && n < 50) begin @(negedge clk); n++; end
    check("rst_test_start_seen", 32'(txd), 0);
    repeat (4 * CPB + 1) @(negedge clk);
    check("pre_reset_data_bit3", 32'(txd), 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_txd", 32'(txd), 1);
    check("midrst_busy", 32'(tx_busy), 0);
    check("midrst_ready", 32'(in_ready), 1);
    check("midrst_sticky", 32'(perr_sticky), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = frames_seen;
    send(9'h1A5, 8'hFF, 1'b1);
    wait_frames(base + 1);
    check("post_reset_line", 32'(last_line), 32'(11'b1_1_10100101_0));

    // Two stop bits on the second instance.
    @(negedge clk);
    in_dp2 = 9'h000; in_valid2 = 1'b1;
    @(posedge clk); #1 in_valid2 = 1'b0;
    n = 0;
    while (txd2 && n < 50) begin @(negedge clk); n++; end
    check("sb2_start_seen", 32'(txd2), 0);
    busy2 = 0; line2 = '0;
    for (int s = 0; s < 60; s++) begin
      if (s > 0) @(negedge clk);
      if (tx_busy2) busy2++;
      if (s < 12 * CPB && s % CPB == 2) line2[s / CPB] = txd2;
    end
    check("sb2_line", 32'(line2), 32'(12'b11_0_00000000_0));
    check("sb2_frame_len", 32'(busy2), 32'(12 * CPB));
    check("sb2_idle_txd", 32'(txd2), 1);

    wait_idle();
    check("scoreboard_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
